if_stage_pc: RTL and testbench
==============================

Name: if_stage_pc

Overview:
Instruction-fetch stage of the pipelined MIPS CPU. It holds the program counter, drives instruction memory, and registers the fetched instruction and PC+4 into the IF/ID pipeline register. It also selects the next PC from sequential, branch and jump sources. It feeds the ID-stage jump-target concatenator (PC+4 upper nibble and 26-bit jump immediate) and consumes that target back as a redirect.

Parameters:
RESET_PC, 32'h00000000, PC value loaded on reset.
NOP_INSTR, 32'h00000000, instruction word inserted into IF/ID on reset or squash.

Ports:
clk  input  1  rising-edge clock
rst_n  input  1  synchronous, active-low reset, sampled on rising clk
stall  input  1  from hazard unit; holds PC and IF/ID
branch_en  input  1  ID-stage taken branch
branch_target  input  32  branch destination
jump_en  input  1  ID-stage J/JAL
jump_target  input  32  {pc_plus_four[31:28], imm26, 2'b00} from ID
imem_addr  output  32  current PC to instruction memory
imem_rdata  input  32  instruction at imem_addr, combinational read
if_id_instr  output  32  registered instruction
if_id_pc_plus_four  output  32  registered PC+4 of that instruction
if_id_valid  output  1  IF/ID holds a real instruction
pc_upper  output  4  if_id_pc_plus_four[31:28], to jump concatenator
jump_imm  output  26  if_id_instr[25:0], to jump concatenator
fetch_count  output  32  count of instructions accepted into IF/ID

Behaviour:
- One clock (clk). Reset is synchronous and active-low (rst_n). All state updates occur on the rising edge of clk.
- Reset (rst_n=0 at an edge): pc=RESET_PC; if_id_instr=NOP_INSTR; if_id_pc_plus_four=0; if_id_valid=0; fetch_count=0. Reset wins over every other input. Reset mid-stream discards all in-flight state.
- imem_addr = pc, combinational. pc_upper and jump_imm are combinational slices of the IF/ID register.
- pc_plus_four = pc + 32'd4, computed modulo 2^32. pc=32'hFFFFFFFC yields 0.
- Next-PC priority, evaluated each edge when not in reset:
  1. stall=1: pc, IF/ID and fetch_count hold. branch_en and jump_en are ignored. ID keeps its instruction, so it re-asserts the redirect once stall drops.
  2. branch_en=1: pc <= {branch_target[31:2],2'b00}. IF/ID squashed (instr=NOP_INSTR, pc_plus_four=0, valid=0). fetch_count holds.
  3. jump_en=1: pc <= {jump_target[31:2],2'b00}. Squash as in case 2. branch_en has priority if both are asserted.
  4. Otherwise: pc <= pc_plus_four; if_id_instr <= imem_rdata; if_id_pc_plus_four <= pc_plus_four; if_id_valid <= 1; fetch_count <= fetch_count+1 (wraps at 2^32).
- There is no branch delay slot. Redirect penalty is one bubble, because the instruction fetched in the redirect cycle is squashed.
- Redirect latency: the redirect is asserted in cycle N, and imem_addr shows the target in cycle N+1. The target instruction appears in IF/ID at N+2.
- The low 2 bits of redirect targets are forced to zero. Misalignment is not flagged.
- No X propagation: outputs are defined from the first reset onward.

Test Plan:
- Reset/sequential: hold rst_n=0 for 2 cycles with RESET_PC=0, then release; imem returns 32'h20080001, 32'h20090002. Expect imem_addr 0,4,8 on successive cycles. Expect if_id_instr=20080001 with pc_plus_four=4 and valid=1, then 20090002 with pc_plus_four=8. fetch_count reaches 2.
- Jump redirect: at pc=8, IF/ID holds 08000010 with pc_plus_four=8. Assert jump_en with jump_target=32'h00000040. Next cycle: imem_addr=40 and IF/ID valid=0 with instr=0. The following cycle: IF/ID holds mem[0x40] with pc_plus_four=44. Expect pc_upper=0 and jump_imm=26'h0000010 while 08000010 is in IF/ID.
- Stall: assert stall for 3 cycles at pc=0x10. imem_addr stays 10, and IF/ID and fetch_count are unchanged. Jump_en pulsed during the stall is ignored. Release stall: pc goes to 14.
- Branch vs jump: assert both with branch_target=32'h100 and jump_target=32'h200. Next imem_addr=100. Misaligned branch_target=32'h103 gives imem_addr=100.
- PC wrap: redirect to 32'hFFFFFFFC with imem_rdata=32'hAAAA5555. Next imem_addr=0. if_id_pc_plus_four=0, pc_upper=0, jump_imm=26'h2AA5555.
- Reset mid-operation: with valid=1 and fetch_count=5, assert rst_n=0 together with jump_en and stall. Next cycle: pc=RESET_PC, valid=0, fetch_count=0.

Source files
------------

// File: rtl/if_stage_pc_if.sv
// Fetch-stage bus: redirect inputs, instruction-memory port and IF/ID register outputs.
// The master side is the fetch stage; the slave side is the surrounding pipeline/memory.
interface if_stage_pc_if;
  logic        stall;
  logic        branch_en;
  logic [31:0] branch_target;
  logic        jump_en;
  logic [31:0] jump_target;
  logic [31:0] imem_addr;
  logic [31:0] imem_rdata;
  logic [31:0] if_id_instr;
  logic [31:0] if_id_pc_plus_four;
  logic        if_id_valid;
  logic [3:0]  pc_upper;
  logic [25:0] jump_imm;
  logic [31:0] fetch_count;

  modport master (
    input  stall, branch_en, branch_target, jump_en, jump_target, imem_rdata,
    output imem_addr, if_id_instr, if_id_pc_plus_four, if_id_valid,
           pc_upper, jump_imm, fetch_count
  );

  modport slave (
    output stall, branch_en, branch_target, jump_en, jump_target, imem_rdata,
    input  imem_addr, if_id_instr, if_id_pc_plus_four, if_id_valid,
           pc_upper, jump_imm, fetch_count
  );
endinterface

// File: rtl/if_stage_pc.sv
// MIPS instruction-fetch stage: program counter, next-PC selection and IF/ID register.
// Redirects squash the instruction fetched in the same cycle (one-bubble penalty).
module if_stage_pc #(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter logic [31:0] NOP_INSTR = 32'h0000_0000
) (
  input logic           clk,
  input logic           rst_n,
  if_stage_pc_if.master bus
);

  logic [31:0] pc;
  logic [31:0] pc_plus_four;
  logic [31:0] instr_q;
  logic [31:0] ppf_q;
  logic        valid_q;
  logic [31:0] count_q;
  logic        redirect;
  logic [31:0] redirect_pc;

  assign pc_plus_four = pc + 32'd4;

  // Masking keeps the full target word in use while forcing word alignment.
  always_comb begin
    redirect    = bus.branch_en | bus.jump_en;
    redirect_pc = bus.branch_en ? (bus.branch_target & ~32'd3)
                                : (bus.jump_target   & ~32'd3);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      pc      <= RESET_PC;
      instr_q <= NOP_INSTR;
      ppf_q   <= '0;
      valid_q <= 1'b0;
      count_q <= '0;
    end else if (!bus.stall) begin
      if (redirect) begin
        pc      <= redirect_pc;
        instr_q <= NOP_INSTR;
        ppf_q   <= '0;
        valid_q <= 1'b0;
      end else begin
        pc      <= pc_plus_four;
        instr_q <= bus.imem_rdata;
        ppf_q   <= pc_plus_four;
        valid_q <= 1'b1;
        count_q <= count_q + 32'd1;
      end
    end
  end

  assign bus.imem_addr          = pc;
  assign bus.if_id_instr        = instr_q;
  assign bus.if_id_pc_plus_four = ppf_q;
  assign bus.if_id_valid        = valid_q;
  assign bus.pc_upper           = ppf_q[31:28];
  assign bus.jump_imm           = instr_q[25:0];
  assign bus.fetch_count        = count_q;

endmodule

// File: tb/tb_if_stage_pc.sv
// Bench for if_stage_pc: directed scenarios plus randomized traffic against a
// cycle-level reference model of the fetch stage.
module tb_if_stage_pc;

  logic clk;
  logic rst_n;
  int   errors;
  int   checks;

  logic [31:0] mem [0:63];

  // Reference model state
  logic [31:0] m_pc;
  logic [31:0] m_instr;
  logic [31:0] m_ppf;
  logic        m_valid;
  logic [31:0] m_cnt;

  if_stage_pc_if bus ();

  if_stage_pc #(
    .RESET_PC (32'h0000_0000),
    .NOP_INSTR(32'h0000_0000)
  ) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  assign bus.imem_rdata = mem[bus.imem_addr[7:2]];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1);
  end

  // Apply one cycle of inputs, advance the model, sample #1 after the edge.
  task automatic cycle(input logic r, input logic s, input logic b, input logic [31:0] bt,
                       input logic j, input logic [31:0] jt);
    logic [31:0] tgt;
    rst_n             = r;
    bus.stall         = s;
    bus.branch_en     = b;
    bus.branch_target = bt;
    bus.jump_en       = j;
    bus.jump_target   = jt;
    if (!r) begin
      m_pc = 32'h0; m_instr = 32'h0; m_ppf = 32'h0; m_valid = 1'b0; m_cnt = 32'h0;
    end else if (s) begin
      // everything holds
    end else if (b || j) begin
      tgt     = b ? bt : jt;
      m_pc    = tgt - (tgt % 4);
      m_instr = 32'h0; m_ppf = 32'h0; m_valid = 1'b0;
    end else begin
      m_instr = mem[m_pc[7:2]];
      m_pc    = m_pc + 4;
      m_ppf   = m_pc;
      m_valid = 1'b1;
      m_cnt   = m_cnt + 1;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset;
    for (int unsigned i = 0; i < 64; i++) mem[i] = 32'h1000_0000 + i;
    cycle(1'b0, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0);
    cycle(1'b0, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0);
    checks++; if (bus.imem_addr !== 32'h0) begin errors++; $display("FAIL reset_pc: got %h expected %h", bus.imem_addr, 32'h0); end
    checks++; if (bus.if_id_instr !== 32'h0) begin errors++; $display("FAIL reset_instr: got %h expected %h", bus.if_id_instr, 32'h0); end
    checks++; if (bus.if_id_pc_plus_four !== 32'h0) begin errors++; $display("FAIL reset_ppf: got %h expected %h", bus.if_id_pc_plus_four, 32'h0); end
    checks++; if (bus.if_id_valid !== 1'b0) begin errors++; $display("FAIL reset_valid: got %b expected 0", bus.if_id_valid); end
    checks++; if (bus.fetch_count !== 32'h0) begin errors++; $display("FAIL reset_count: got %h expected 0", bus.fetch_count); end
  endtask

  task automatic test_sequential;
    mem[0] = 32'h2008_0001;
    mem[1] = 32'h2009_0002;
    cycle(1'b1, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0);
    checks++; if (bus.imem_addr !== 32'h4) begin errors++; $display("FAIL seq_pc1: got %h expected %h", bus.imem_addr, 32'h4); end
    checks++; if (bus.if_id_instr !== 32'h2008_0001) begin errors++; $display("FAIL seq_instr1: got %h expected %h", bus.if_id_instr, 32'h2008_0001); end
    checks++; if (bus.if_id_pc_plus_four !== 32'h4) begin errors++; $display("FAIL seq_ppf1: got %h expected %h", bus.if_id_pc_plus_four, 32'h4); end
    checks++; if (bus.if_id_valid !== 1'b1) begin errors++; $display("FAIL seq_valid1: got %b expected 1", bus.if_id_valid); end
    cycle(1'b1, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0);
    checks++; if (bus.imem_addr !== 32'h8) begin errors++; $display("FAIL seq_pc2: got %h expected %h", bus.imem_addr, 32'h8); end
    checks++; if (bus.if_id_instr !== 32'h2009_0002) begin errors++; $display("FAIL seq_instr2: got %h expected %h", bus.if_id_instr, 32'h2009_0002); end
    checks++; if (bus.if_id_pc_plus_four !== 32'h8) begin errors++; $display("FAIL seq_ppf2: got %h expected %h", bus.if_id_pc_plus_four, 32'h8); end
    checks++; if (bus.fetch_count !== 32'd2) begin errors++; $display("FAIL seq_count: got %0d expected 2", bus.fetch_count); end
  endtask

  task automatic test_jump;
    mem[1]    = 32'h0800_0010;
    mem[5'h10] = 32'h2400_4040;
    cycle(1'b0, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0);
    cycle(1'b1, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0);
    cycle(1'b1, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0);
    checks++; if (bus.if_id_instr !== 32'h0800_0010) begin errors++; $display("FAIL jmp_id_instr: got %h expected %h", bus.if_id_instr, 32'h0800_0010); end
    checks++; if (bus.pc_upper !== 4'h0) begin errors++; $display("FAIL jmp_pc_upper: got %h expected 0", bus.pc_upper); end
    checks++; if (bus.jump_imm !== 26'h000_0010) begin errors++; $display("FAIL jmp_imm: got %h expected %h", bus.jump_imm, 26'h000_0010); end
    cycle(1'b1, 1'b0, 1'b0, 32'h0, 1'b1, 32'h0000_0040);
    checks++; if (bus.imem_addr !== 32'h40) begin errors++; $display("FAIL jmp_target: got %h expected %h", bus.imem_addr, 32'h40); end
    checks++; if (bus.if_id_valid !== 1'b0 || bus.if_id_instr !== 32'h0) begin errors++; $display("FAIL jmp_squash: got valid=%b instr=%h expected valid=0 instr=0", bus.if_id_valid, bus.if_id_instr); end
    cycle(1'b1, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0);
    checks++; if (bus.if_id_instr !== 32'h2400_4040 || bus.if_id_pc_plus_four !== 32'h44) begin errors++; $display("FAIL jmp_fetch: got instr=%h ppf=%h expected instr=24004040 ppf=44", bus.if_id_instr, bus.if_id_pc_plus_four); end
    checks++; if (bus.fetch_count !== 32'd3) begin errors++; $display("FAIL jmp_count: got %0d expected 3", bus.fetch_count); end
  endtask

  task automatic test_stall;
    cycle(1'b0, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0);
    for (int unsigned i = 0; i < 4; i++) cycle(1'b1, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0);
    for (int unsigned i = 0; i < 3; i++) begin
      cycle(1'b1, 1'b1, 1'b0, 32'h0, (i == 1), 32'h0000_0300);
      checks++; if (bus.imem_addr !== 32'h10) begin errors++; $display("FAIL stall_pc: got %h expected %h", bus.imem_addr, 32'h10); end
      checks++; if (bus.if_id_instr !== mem[3] || bus.if_id_pc_plus_four !== 32'h10 || bus.if_id_valid !== 1'b1) begin
        errors++; $display("FAIL stall_ifid: got instr=%h ppf=%h valid=%b expected instr=%h ppf=10 valid=1", bus.if_id_instr, bus.if_id_pc_plus_four, bus.if_id_valid, mem[3]);
      end
      checks++; if (bus.fetch_count !== 32'd4) begin errors++; $display("FAIL stall_count: got %0d expected 4", bus.fetch_count); end
    end
    cycle(1'b1, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0);
    checks++; if (bus.imem_addr !== 32'h14) begin errors++; $display("FAIL stall_release: got %h expected %h", bus.imem_addr, 32'h14); end
  endtask

  task automatic test_branch_vs_jump;
    cycle(1'b1, 1'b0, 1'b1, 32'h0000_0100, 1'b1, 32'h0000_0200);
    checks++; if (bus.imem_addr !== 32'h100) begin errors++; $display("FAIL br_priority: got %h expected %h", bus.imem_addr, 32'h100); end
    cycle(1'b1, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0);
    cycle(1'b1, 1'b0, 1'b1, 32'h0000_0103, 1'b0, 32'h0);
    checks++; if (bus.imem_addr !== 32'h100) begin errors++; $display("FAIL br_align: got %h expected %h", bus.imem_addr, 32'h100); end
    checks++; if (bus.if_id_valid !== 1'b0) begin errors++; $display("FAIL br_squash: got %b expected 0", bus.if_id_valid); end
  endtask

  task automatic test_pc_wrap;
    mem[63] = 32'hAAAA_5555;
    cycle(1'b1, 1'b0, 1'b0, 32'h0, 1'b1, 32'hFFFF_FFFC);
    checks++; if (bus.imem_addr !== 32'hFFFF_FFFC) begin errors++; $display("FAIL wrap_target: got %h expected %h", bus.imem_addr, 32'hFFFF_FFFC); end
    cycle(1'b1, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0);
    checks++; if (bus.imem_addr !== 32'h0) begin errors++; $display("FAIL wrap_pc: got %h expected 0", bus.imem_addr); end
    checks++; if (bus.if_id_pc_plus_four !== 32'h0) begin errors++; $display("FAIL wrap_ppf: got %h expected 0", bus.if_id_pc_plus_four); end
    checks++; if (bus.pc_upper !== 4'h0) begin errors++; $display("FAIL wrap_upper: got %h expected 0", bus.pc_upper); end
    checks++; if (bus.jump_imm !== 26'h2AA_5555) begin errors++; $display("FAIL wrap_imm: got %h expected %h", bus.jump_imm, 26'h2AA_5555); end
  endtask

  task automatic test_reset_mid;
    cycle(1'b0, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0);
    for (int unsigned i = 0; i < 5; i++) cycle(1'b1, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0);
    checks++; if (bus.fetch_count !== 32'd5 || bus.if_id_valid !== 1'b1) begin errors++; $display("FAIL mid_pre: got count=%0d valid=%b expected count=5 valid=1", bus.fetch_count, bus.if_id_valid); end
    cycle(1'b0, 1'b1, 1'b0, 32'h0, 1'b1, 32'h0000_0080);
    checks++; if (bus.imem_addr !== 32'h0) begin errors++; $display("FAIL mid_pc: got %h expected 0", bus.imem_addr); end
    checks++; if (bus.if_id_valid !== 1'b0) begin errors++; $display("FAIL mid_valid: got %b expected 0", bus.if_id_valid); end
    checks++; if (bus.fetch_count !== 32'h0) begin errors++; $display("FAIL mid_count: got %0d expected 0", bus.fetch_count); end
  endtask

  task automatic test_random;
    logic        r, s, b, j;
    logic [31:0] bt, jt;
    for (int unsigned i = 0; i < 64; i++) mem[i] = $urandom;
    for (int unsigned n = 0; n < 400; n++) begin
      r  = ($urandom_range(0, 99) >= 3);
      s  = ($urandom_range(0, 99) < 25);
      b  = ($urandom_range(0, 99) < 12);
      j  = ($urandom_range(0, 99) < 12);
      bt = $urandom;
      jt = $urandom;
      cycle(r, s, b, bt, j, jt);
      checks++; if (bus.imem_addr !== m_pc) begin errors++; $display("FAIL rnd_pc[%0d]: got %h expected %h", n, bus.imem_addr, m_pc); end
      checks++; if (bus.if_id_instr !== m_instr) begin errors++; $display("FAIL rnd_instr[%0d]: got %h expected %h", n, bus.if_id_instr, m_instr); end
      checks++; if (bus.if_id_pc_plus_four !== m_ppf) begin errors++; $display("FAIL rnd_ppf[%0d]: got %h expected %h", n, bus.if_id_pc_plus_four, m_ppf); end
      checks++; if (bus.if_id_valid !== m_valid) begin errors++; $display("FAIL rnd_valid[%0d]: got %b expected %b", n, bus.if_id_valid, m_valid); end
      checks++; if (bus.pc_upper !== m_ppf[31:28] || bus.jump_imm !== m_instr[25:0]) begin
        errors++; $display("FAIL rnd_slices[%0d]: got upper=%h imm=%h expected upper=%h imm=%h", n, bus.pc_upper, bus.jump_imm, m_ppf[31:28], m_instr[25:0]);
      end
      checks++; if (bus.fetch_count !== m_cnt) begin errors++; $display("FAIL rnd_count[%0d]: got %0d expected %0d", n, bus.fetch_count, m_cnt); end
    end
  endtask

  initial begin
    errors = 0;
    checks = 0;
    rst_n = 1'b0;
    bus.stall = 1'b0;
    bus.branch_en = 1'b0;
    bus.branch_target = 32'h0;
    bus.jump_en = 1'b0;
    bus.jump_target = 32'h0;
    @(negedge clk);
    test_reset;
    test_sequential;
    test_jump;
    test_stall;
    test_branch_vs_jump;
    test_pc_wrap;
    test_reset_mid;
    test_random;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
